midi_msg_parser: RTL and testbench
==================================

# midi_msg_parser

Byte-level MIDI message parser sitting directly downstream of the UART receiver in the synthesizer front end. It consumes received bytes (8-bit data plus a one-cycle ready strobe) and assembles complete channel-voice messages, including running status. It emits one-cycle event pulses (note on, note off, control change, pitch bend) to the voice allocator. All other traffic is parsed only for correct byte counting and then discarded.

## Interface
- OMNI, default 1: 1 = accept all channels; 0 = accept only the channel on chan_sel.
- clk  in  1  system clock, the same clock as the UART receiver.
- reset  in  1  asynchronous, active-high.
- rx_data  in  8  received byte; valid only in the cycle rx_ready=1.
- rx_ready  in  1  one-cycle strobe, one per received byte.
- chan_sel  in  4  channel filter, used when OMNI=0; sampled every byte.
- ev_valid  out  1  one-cycle event strobe.
- ev_type  out  2  event type: 00 note off, 01 note on, 10 control change, 11 pitch bend.
- ev_chan  out  4  MIDI channel, 0-15.
- ev_d1  out  7  note / controller number / pitch-bend LSB.
- ev_d2  out  7  velocity / controller value / pitch-bend MSB.
- rs_valid  out  1  running status currently held (debug).

## Operation
- Byte classes:
  - Status byte: rx_data[7]=1.
  - Data byte: rx_data[7]=0.
  - Real-time byte: 0xF8-0xFF.
- Registers: running status rs[7:0] with rs_valid, first data byte d1_hold[6:0], FSM state.
- FSM states:
  - IDLE: no message in progress.
  - WAIT_D1: expecting the first data byte.
  - WAIT_D2: expecting the second data byte.
  - SYSEX: inside a system-exclusive message.
  - SKIP1: one system-common data byte to discard.
  - SKIP2: two system-common data bytes to discard.
- Channel status 0x80-0xEF:
  - Load rs and set rs_valid.
  - Go to WAIT_D1 from any state; a partial message in progress is abandoned without an event.
- Data byte handling:
  - In WAIT_D1: store it in d1_hold.
    - 2-byte types (8n, 9n, An, Bn, En): go to WAIT_D2.
    - 1-byte types (Cn, Dn): message complete; return to WAIT_D1.
  - In WAIT_D2: message complete; return to WAIT_D1, which is the running-status re-arm.
  - In IDLE with rs_valid=0: discard.
- Event emission on message completion, only when OMNI=1 or rs[3:0]==chan_sel:
  - 8n: type 00.
  - 9n: type 01, except velocity 0 is emitted as type 00 with d2=0.
  - Bn: type 10.
  - En: type 11.
  - An, Cn, Dn: no event.
- 0xF0: clear rs_valid and enter SYSEX.
  - In SYSEX, data bytes are ignored.
  - 0xF7 or any non-real-time status byte exits SYSEX. A channel status byte is processed normally, so it also loads rs.
- System common 0xF1-0xF7: clear rs_valid, then:
  - F1, F3: go to SKIP1.
  - F2: go to SKIP2.
  - F4, F5, F6, F7 (outside SYSEX): go to IDLE.
  - SKIP1/SKIP2 count down on data bytes, then go to IDLE. A status byte during a skip is processed normally.
- Real-time bytes 0xF8-0xFF: ignored in every state. They change neither state, rs, nor d1_hold.

## Timing
- Reset values: state=IDLE, rs=0, rs_valid=0, ev_valid=0, ev_type=0, ev_chan=0, ev_d1=0, ev_d2=0.
- The FSM advances only in cycles with rx_ready=1; otherwise everything holds.
- Latency: ev_valid is high exactly one cycle, in the cycle after the rx_ready of the completing byte.
- ev_type, ev_chan, ev_d1 and ev_d2 are registered. They update together with ev_valid and hold their values until the next event.
- Back-to-back rx_ready strobes on consecutive cycles are supported at full rate. The UART cannot produce them, but the bench must exercise them.
- chan_sel is compared when the completing byte arrives, not when the status byte arrives.
- Reset asserted mid-message: all state clears and running status is lost. The next data byte is discarded.

## Structure
- Shared package midi_pkg holds:
  - Event type codes EV_NOTE_OFF, EV_NOTE_ON, EV_CC, EV_PBEND.
  - Status constants ST_SYSEX=8'hF0, ST_EOX=8'hF7, RT_MIN=8'hF8.
  - The FSM state encoding.
- One sub-module: midi_len_decode, combinational. It maps a status byte to the number of data bytes (0/1/2) and an emit flag, and is reusable by a future MIDI transmit path.

## Test plan
- Note on, full: 90 3C 64 -> one ev_valid with type 01, chan 0, d1 3C, d2 64, one cycle after the third byte.
- Running status with vel-0 off: 91 40 50 40 00 -> events (01, 1, 40, 50), then (00, 1, 40, 00).
- Real-time interleave: 90 F8 3C FE 64 -> a single note-on event 3C/64; state unchanged by F8 and FE.
- SysEx: F0 7E 00 F7 3C 64 -> no events; rs_valid=0 after F0, and trailing data is discarded.
- Channel filter with OMNI=0, chan_sel=2: 92 30 40 93 30 40 -> only the channel-2 event is emitted.
- Abandon and reset: 90 3C B0 07 7F -> a CC event (10, 0, 07, 7F) and no note event. Then reset after 90 3C, followed by 40 -> no event.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared constants and encodings for the MIDI receive path.
// Event codes, status byte landmarks and parser FSM states.
package midi_pkg;

    localparam logic [1:0] EV_NOTE_OFF = 2'b00;
    localparam logic [1:0] EV_NOTE_ON  = 2'b01;
    localparam logic [1:0] EV_CC       = 2'b10;
    localparam logic [1:0] EV_PBEND    = 2'b11;

    localparam logic [7:0] ST_SYSEX = 8'hF0;
    localparam logic [7:0] ST_EOX   = 8'hF7;
    localparam logic [7:0] RT_MIN   = 8'hF8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_D1 = 3'd1,
        ST_WAIT_D2 = 3'd2,
        ST_SYSX    = 3'd3,
        ST_SKIP1   = 3'd4,
        ST_SKIP2   = 3'd5
    } state_t;

endpackage

// File: rtl/midi_len_decode.sv
// Status byte -> data byte count and whether completion yields an event.
// Pure combinational; shared between receive and a future transmit path.
module midi_len_decode
    import midi_pkg::*;
(
    input  logic [7:0] i_status,
    output logic [1:0] o_len,
    output logic       o_emit
);

    always_comb begin
        o_len  = 2'd0;
        o_emit = 1'b0;
        case (i_status[7:4])
            4'h8, 4'h9, 4'hB, 4'hE: begin
                o_len  = 2'd2;
                o_emit = 1'b1;
            end
            4'hA:       o_len = 2'd2;
            4'hC, 4'hD: o_len = 2'd1;
            4'hF: begin
                case (i_status[3:0])
                    4'h1, 4'h3: o_len = 2'd1;
                    4'h2:       o_len = 2'd2;
                    default:    o_len = 2'd0;
                endcase
            end
            default: o_len = 2'd0;
        endcase
    end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI byte stream parser: running status, sysex/common skipping and
// one-cycle channel-voice event strobes for the voice allocator.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter bit OMNI = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic [3:0] chan_sel,
    output logic       ev_valid,
    output logic [1:0] ev_type,
    output logic [3:0] ev_chan,
    output logic [6:0] ev_d1,
    output logic [6:0] ev_d2,
    output logic       rs_valid
);

    state_t      r_state, w_state_nx;
    logic [7:0]  r_rs, w_rs_nx;
    logic        r_rs_valid, w_rsv_nx;
    logic [6:0]  r_d1, w_d1_nx;
    logic        r_ev_valid, w_ev_valid_nx;
    logic [1:0]  r_ev_type, w_ev_type_nx;
    logic [3:0]  r_ev_chan, w_ev_chan_nx;
    logic [6:0]  r_ev_d1, w_ev_d1_nx;
    logic [6:0]  r_ev_d2, w_ev_d2_nx;

    logic [7:0]  w_dec_in;
    logic [1:0]  w_len;
    logic        w_emit;
    logic        w_done;
    logic        w_chan_ok;

    // Status bytes are decoded directly; data bytes use the held status.
    assign w_dec_in = rx_data[7] ? rx_data : r_rs;

    midi_len_decode u_len (
        .i_status (w_dec_in),
        .o_len    (w_len),
        .o_emit   (w_emit)
    );

    assign w_chan_ok = OMNI || (r_rs[3:0] == chan_sel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rs       <= 8'h00;
            r_rs_valid <= 1'b0;
            r_d1       <= 7'h00;
            r_ev_valid <= 1'b0;
            r_ev_type  <= 2'b00;
            r_ev_chan  <= 4'h0;
            r_ev_d1    <= 7'h00;
            r_ev_d2    <= 7'h00;
        end else begin
            r_state    <= w_state_nx;
            r_rs       <= w_rs_nx;
            r_rs_valid <= w_rsv_nx;
            r_d1       <= w_d1_nx;
            r_ev_valid <= w_ev_valid_nx;
            r_ev_type  <= w_ev_type_nx;
            r_ev_chan  <= w_ev_chan_nx;
            r_ev_d1    <= w_ev_d1_nx;
            r_ev_d2    <= w_ev_d2_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_rs_nx    = r_rs;
        w_rsv_nx   = r_rs_valid;
        w_d1_nx    = r_d1;
        w_done     = 1'b0;
        if (rx_ready) begin
            if (rx_data >= RT_MIN) begin
                w_state_nx = r_state;
            end else if (rx_data[7]) begin
                if (rx_data < ST_SYSEX) begin
                    w_rs_nx    = rx_data;
                    w_rsv_nx   = 1'b1;
                    w_state_nx = ST_WAIT_D1;
                end else begin
                    w_rsv_nx = 1'b0;
                    if (rx_data == ST_SYSEX) begin
                        w_state_nx = ST_SYSX;
                    end else if (w_len == 2'd1) begin
                        w_state_nx = ST_SKIP1;
                    end else if (w_len == 2'd2) begin
                        w_state_nx = ST_SKIP2;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
            end else begin
                case (r_state)
                    ST_WAIT_D1: begin
                        w_d1_nx    = rx_data[6:0];
                        w_state_nx = (w_len == 2'd2) ? ST_WAIT_D2
                                                     : ST_WAIT_D1;
                    end
                    ST_WAIT_D2: begin
                        w_state_nx = ST_WAIT_D1;
                        w_done     = 1'b1;
                    end
                    ST_SKIP2: w_state_nx = ST_SKIP1;
                    ST_SKIP1: w_state_nx = ST_IDLE;
                    default:  w_state_nx = r_state;
                endcase
            end
        end
    end

    always_comb begin
        w_ev_valid_nx = 1'b0;
        w_ev_type_nx  = r_ev_type;
        w_ev_chan_nx  = r_ev_chan;
        w_ev_d1_nx    = r_ev_d1;
        w_ev_d2_nx    = r_ev_d2;
        if (w_done && w_emit && w_chan_ok) begin
            w_ev_valid_nx = 1'b1;
            w_ev_chan_nx  = r_rs[3:0];
            w_ev_d1_nx    = r_d1;
            w_ev_d2_nx    = rx_data[6:0];
            case (r_rs[6:4])
                3'h0: w_ev_type_nx = EV_NOTE_OFF;
                // Note on with zero velocity is a note off by MIDI rule.
                3'h1: w_ev_type_nx = (rx_data[6:0] == 7'h00) ? EV_NOTE_OFF
                                                             : EV_NOTE_ON;
                3'h3: w_ev_type_nx = EV_CC;
                default: w_ev_type_nx = EV_PBEND;
            endcase
        end
    end

    assign ev_valid = r_ev_valid;
    assign ev_type  = r_ev_type;
    assign ev_chan  = r_ev_chan;
    assign ev_d1    = r_ev_d1;
    assign ev_d2    = r_ev_d2;
    assign rs_valid = r_rs_valid;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed bench: an OMNI instance and a channel-2-only instance share
// one byte stream; events are checked one cycle after the last byte.
module tb_midi_msg_parser;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [3:0] chan_sel;

    logic       a_v, b_v, a_rs, b_rs;
    logic [1:0] a_t, b_t;
    logic [3:0] a_c, b_c;
    logic [6:0] a_d1, b_d1, a_d2, b_d2;

    int errs = 0;
    int checks = 0;
    int cnt_a = 0;
    int cnt_b = 0;

    always #5 clk = ~clk;

    midi_msg_parser #(.OMNI(1'b1)) u_a (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
        .chan_sel(chan_sel), .ev_valid(a_v), .ev_type(a_t), .ev_chan(a_c),
        .ev_d1(a_d1), .ev_d2(a_d2), .rs_valid(a_rs)
    );

    midi_msg_parser #(.OMNI(1'b0)) u_b (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
        .chan_sel(chan_sel), .ev_valid(b_v), .ev_type(b_t), .ev_chan(b_c),
        .ev_d1(b_d1), .ev_d2(b_d2), .rs_valid(b_rs)
    );

    always @(negedge clk) begin
        if (a_v) cnt_a <= cnt_a + 1;
        if (b_v) cnt_b <= cnt_b + 1;
    end

    function automatic logic [20:0] ev(input logic v, input logic [1:0] t,
                                       input logic [3:0] c,
                                       input logic [6:0] d1,
                                       input logic [6:0] d2);
        return {v, t, c, d1, d2};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_ready = 1'b0;
        chan_sel = 4'd2;
        idle(3);
        reset = 1'b0;
        idle(1);
        chk("reset_a", {a_rs, a_v, a_t, a_c, a_d1, a_d2}, 32'h0);
        chk("reset_b", {b_rs, b_v, b_t, b_c, b_d1, b_d2}, 32'h0);

        // full note on, back-to-back bytes
        put(8'h90);
        chk("rs_after_90", a_rs, 1);
        put(8'h3C);
        put(8'h64);
        chk("non_full", {a_v, a_t, a_c, a_d1, a_d2}, ev(1, 1, 0, 7'h3C, 7'h64));
        idle(1);
        chk("non_pulse", {a_v, a_t, a_c, a_d1, a_d2}, ev(0, 1, 0, 7'h3C, 7'h64));

        // running status with velocity-0 off
        idle(2);
        put(8'h91);
        idle(1);
        put(8'h40);
        put(8'h50);
        chk("rs_on", {a_v, a_t, a_c, a_d1, a_d2}, ev(1, 1, 1, 7'h40, 7'h50));
        idle(3);
        put(8'h40);
        put(8'h00);
        chk("rs_vel0", {a_v, a_t, a_c, a_d1, a_d2}, ev(1, 0, 1, 7'h40, 7'h00));

        // real-time interleave
        idle(2);
        put(8'h90);
        put(8'hF8);
        chk("rt_rs", a_rs, 1);
        put(8'h3C);
        put(8'hFE);
        chk("rt_noev", a_v, 0);
        put(8'h64);
        chk("rt_ev", {a_v, a_t, a_c, a_d1, a_d2}, ev(1, 1, 0, 7'h3C, 7'h64));
        idle(2);
        chk("cnt_a_4", cnt_a, 4);

        // sysex then orphan data
        put(8'hF0);
        chk("sysex_rs", a_rs, 0);
        put(8'h7E);
        put(8'h00);
        put(8'hF7);
        put(8'h3C);
        put(8'h64);
        idle(2);
        chk("sysex_cnt", cnt_a, 4);
        chk("sysex_rs2", a_rs, 0);

        // channel filter on instance b
        put(8'h92);
        put(8'h30);
        put(8'h40);
        chk("flt_b2", {b_v, b_t, b_c, b_d1, b_d2}, ev(1, 1, 2, 7'h30, 7'h40));
        put(8'h93);
        put(8'h30);
        put(8'h40);
        chk("flt_b3", {b_v, b_t, b_c, b_d1, b_d2}, ev(0, 1, 2, 7'h30, 7'h40));
        chk("flt_a3", {a_v, a_t, a_c, a_d1, a_d2}, ev(1, 1, 3, 7'h30, 7'h40));
        idle(2);
        chk("flt_cnt_a", cnt_a, 6);
        chk("flt_cnt_b", cnt_b, 1);

        // abandon partial note by CC
        put(8'h90);
        put(8'h3C);
        put(8'hB0);
        put(8'h07);
        put(8'h7F);
        chk("cc_ev", {a_v, a_t, a_c, a_d1, a_d2}, ev(1, 2, 0, 7'h07, 7'h7F));
        idle(2);
        chk("cc_cnt", cnt_a, 7);

        // song position skip, then F1 broken by pitch bend
        put(8'hF2);
        put(8'h10);
        put(8'h20);
        put(8'h3C);
        put(8'h64);
        idle(2);
        chk("skip_cnt", cnt_a, 7);
        chk("skip_rs", a_rs, 0);
        put(8'hF1);
        put(8'hE5);
        put(8'h00);
        put(8'h40);
        chk("pb_ev", {a_v, a_t, a_c, a_d1, a_d2}, ev(1, 3, 5, 7'h00, 7'h40));

        // program change, channel pressure, poly AT: no events
        put(8'hC0);
        put(8'h05);
        put(8'h06);
        put(8'hD1);
        put(8'h10);
        put(8'hA0);
        put(8'h3C);
        put(8'h40);
        idle(2);
        chk("noev_cnt", cnt_a, 8);

        // reset mid-message
        put(8'h90);
        put(8'h3C);
        reset = 1'b1;
        #2;
        chk("rst_mid", {a_rs, a_v, a_t, a_c, a_d1, a_d2}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        put(8'h40);
        idle(2);
        chk("rst_cnt", cnt_a, 8);
        chk("rst_rs", a_rs, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
